// File: rtl/alu_cmd_sequencer.sv
// Command/response wrapper around the 8-bit ALU: latches operands, masks stale done,
// captures op1/op2/op3 with timeout. Optional macro ALU_SEQ_DIV0_CHECK_EN short-circuits div-by-zero.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_a,
  input  logic [7:0]  i_cmd_b,
  input  logic [2:0]  i_cmd_mode,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [2:0]  o_alu_mode,
  input  logic [7:0]  i_alu_op1,
  input  logic [7:0]  i_alu_op2,
  input  logic [15:0] i_alu_op3,
  input  logic        i_alu_done,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [7:0]  o_rsp_lo,
  output logic [7:0]  o_rsp_hi,
  output logic [15:0] o_rsp_wide,
  output logic [1:0]  o_rsp_err,
  output logic        o_busy
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_set_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic [TW-1:0]  w_to_nxt;
  logic [7:0]     r_alu_a, r_alu_b;
  logic [2:0]     r_alu_mode;
  logic [7:0]     r_rsp_lo, r_rsp_hi;
  logic [15:0]    r_rsp_wide;
  logic [1:0]     r_rsp_err;

  // Cycles spent in WAIT including the current one.
  assign w_to_nxt = r_to_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_set_cnt  <= '0;
      r_to_cnt   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_mode <= '0;
      r_rsp_lo   <= '0;
      r_rsp_hi   <= '0;
      r_rsp_wide <= '0;
      r_rsp_err  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_alu_a    <= i_cmd_a;
            r_alu_b    <= i_cmd_b;
            r_alu_mode <= i_cmd_mode;
            r_set_cnt  <= '0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
            if (i_cmd_mode == 3'b011 && i_cmd_b == 8'h00) begin
              r_rsp_lo   <= 8'hFF;
              r_rsp_hi   <= i_cmd_a;
              r_rsp_wide <= '0;
              r_rsp_err  <= 2'b10;
              r_state    <= S_RESP;
            end else
`endif
              r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Done is ignored here: the ALU may still report the previous operands.
          if (r_set_cnt >= SET_LAST) begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_alu_done) begin
            r_rsp_lo   <= i_alu_op1;
            r_rsp_hi   <= i_alu_op2;
            r_rsp_wide <= i_alu_op3;
            r_rsp_err  <= 2'b00;
            r_state    <= S_RESP;
          end else if (w_to_nxt >= TO_MAX) begin
            r_rsp_lo   <= '0;
            r_rsp_hi   <= '0;
            r_rsp_wide <= '0;
            r_rsp_err  <= 2'b01;
            r_state    <= S_RESP;
          end else begin
            r_to_cnt <= w_to_nxt;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_mode  = r_alu_mode;
  assign o_rsp_lo    = r_rsp_lo;
  assign o_rsp_hi    = r_rsp_hi;
  assign o_rsp_wide  = r_rsp_wide;
  assign o_rsp_err   = r_rsp_err;

endmodule
